// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - multi-channel divided tick/phase generator with staggered reset release
module clk_rst_sequencer #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 8,
    parameter int DLY_W    = 8,
    parameter int HOLD_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_CH*DIV_W-1:0]   cfg_div,
    input  logic [NUM_CH*DLY_W-1:0]   cfg_dly,
    input  logic                      cfg_load,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      sw_rst_req,
    output logic [NUM_CH-1:0]         ch_rstn,
    output logic [NUM_CH-1:0]         ch_tick,
    output logic [NUM_CH-1:0]         ch_phase,
    output logic                      busy,
    output logic                      seq_done
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int CNT_W  = (DLY_W > HOLD_W) ? DLY_W : HOLD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]              sync;
    logic                    rst_s;
    logic [1:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        nxt_idx;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CH*DIV_W-1:0] sh_div;
    logic [NUM_CH*DLY_W-1:0] sh_dly;
    logic [DLY_W-1:0]        dly_first;
    logic [DLY_W-1:0]        dly_nxt;
    logic                    load_ok;
    logic [DIV_W-1:0]        dcnt [NUM_CH];
    logic [DIV_W-1:0]        dm1  [NUM_CH];

    assign rst_s     = sync[1];
    assign load_ok   = rst_s && cfg_load && ((state == IDLE) || (state == DONE));
    assign nxt_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    assign dly_first = sh_dly[DLY_W-1:0];
    assign dly_nxt   = sh_dly[nxt_idx*DLY_W +: DLY_W];

    // Release of the global reset is synchronised; assertion stays asynchronous
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync <= 2'b00;
        else       sync <= {sync[0], 1'b1};
    end

    // Shadow config follows the inputs until the sequencer starts, then only on an accepted load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_div <= '0;
            sh_dly <= '0;
        end else if (!rst_s || load_ok) begin
            sh_div <= cfg_div;
            sh_dly <= cfg_dly;
        end
    end

    // Release sequencer: one channel per slot, each slot lasting its delay plus one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            ch_rstn  <= '0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            // busy rises with the cycle that enters REL/HOLD and drops one cycle after the last release
            busy     <= (state == REL) || (state == HOLD) ||
                        ((state == IDLE) && rst_s) || ((state == DONE) && sw_rst_req);
            seq_done <= (state == DONE) && !sw_rst_req;
            case (state)
                IDLE: begin
                    if (rst_s) begin
                        state <= REL;
                        idx   <= '0;
                        cnt   <= CNT_W'(dly_first);
                    end
                end
                REL: begin
                    if (cnt == '0) begin
                        ch_rstn[idx] <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx <= nxt_idx;
                            cnt <= CNT_W'(dly_nxt);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (sw_rst_req) begin
                        state   <= HOLD;
                        ch_rstn <= '0;
                        cnt     <= CNT_W'(HOLD_CYC - 1);
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= REL;
                        idx   <= '0;
                        cnt   <= CNT_W'(dly_first);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // Terminal count per channel; a zero divisor behaves as divide-by-one
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dm1[i] = (sh_div[i*DIV_W +: DIV_W] == '0) ? '0 : sh_div[i*DIV_W +: DIV_W] - 1'b1;
        end
    end

    // Per-channel dividers, parked at zero while in reset, disabled, or being reconfigured
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) dcnt[i] <= '0;
            ch_tick  <= '0;
            ch_phase <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_rstn[i] || !ch_en[i] || load_ok) begin
                    dcnt[i]     <= '0;
                    ch_tick[i]  <= 1'b0;
                    ch_phase[i] <= 1'b0;
                end else if (dcnt[i] == dm1[i]) begin
                    dcnt[i]     <= '0;
                    ch_tick[i]  <= 1'b1;
                    ch_phase[i] <= ~ch_phase[i];
                end else begin
                    dcnt[i]    <= dcnt[i] + 1'b1;
                    ch_tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb/tb_clk_rst_sequencer.sv - randomized scoreboard bench for clk_rst_sequencer
module tb_clk_rst_sequencer;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int LW  = 8;
    localparam int HC  = 16;
    localparam int INF = 1 << 30;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N*DW-1:0] cfg_div;
    logic [N*LW-1:0] cfg_dly;
    logic            cfg_load;
    logic [N-1:0]    ch_en;
    logic            sw_rst_req;
    logic [N-1:0]    ch_rstn;
    logic [N-1:0]    ch_tick;
    logic [N-1:0]    ch_phase;
    logic            busy;
    logic            seq_done;

    clk_rst_sequencer #(.NUM_CH(N), .DIV_W(DW), .DLY_W(LW), .HOLD_CYC(HC)) dut (
        .clk(clk), .rstn(rstn), .cfg_div(cfg_div), .cfg_dly(cfg_dly), .cfg_load(cfg_load),
        .ch_en(ch_en), .sw_rst_req(sw_rst_req), .ch_rstn(ch_rstn), .ch_tick(ch_tick),
        .ch_phase(ch_phase), .busy(busy), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int ch; int cyc; } ev_t;
    ev_t evq[$];

    // reference model: values currently in the DUT shadow, pending input values, and event times
    int p_dly[N], p_div[N], m_dly[N], m_div[N];
    int rel[N], last_rel[N], en_from[N];
    bit m_en[N], prev_exp[N], prev_dut[N];
    int load_from, busy_from, busy_to, done_from;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Monitor: compares every sampled cycle against the model and the release queue
    always @(negedge clk) begin
        bit er, act, et, ep;
        int st, k, d;
        ev_t ev;
        for (int i = 0; i < N; i++) begin
            er = (cyc >= rel[i]);
            if (er && !prev_exp[i]) last_rel[i] = cyc;
            chk("ch_rstn_level", ch_rstn[i], er);
            if (ch_rstn[i] && !prev_dut[i]) begin
                chk("release_expected", evq.size() > 0, 1);
                if (evq.size() > 0) begin
                    ev = evq.pop_front();
                    chk("release_channel", i, ev.ch);
                    chk("release_cycle", cyc, ev.cyc);
                end
            end
            act = m_en[i] && prev_exp[i];
            et = 0;
            ep = 0;
            if (act) begin
                st = max3(last_rel[i], en_from[i], load_from);
                k  = cyc - st;
                d  = (m_div[i] == 0) ? 1 : m_div[i];
                if (k >= 0) begin
                    et = (k > 0) && (k % d == 0);
                    ep = ((k / d) % 2) == 1;
                end
            end
            chk($sformatf("ch_tick%0d", i), ch_tick[i], et);
            chk($sformatf("ch_phase%0d", i), ch_phase[i], ep);
            prev_exp[i] = er;
            prev_dut[i] = ch_rstn[i];
        end
        chk("busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
        chk("seq_done", seq_done, cyc >= done_from);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < N; i++) begin
            cfg_div[i*DW +: DW] = DW'(p_div[i]);
            cfg_dly[i*LW +: LW] = LW'(p_dly[i]);
        end
    endtask

    // Expected release schedule once REL is entered at edge s
    task automatic start_seq(input int s);
        int t;
        ev_t ev;
        t = s;
        for (int i = 0; i < N; i++) begin
            t = t + m_dly[i] + 1;
            rel[i] = t;
            ev.ch = i;
            ev.cyc = t;
            evq.push_back(ev);
        end
        busy_to   = t;
        done_from = t + 1;
    endtask

    task automatic power_up();
        for (int i = 0; i < N; i++) begin
            m_dly[i] = p_dly[i];
            m_div[i] = p_div[i];
        end
        step();
        rstn = 1'b1;
        busy_from = cyc + 3;
        start_seq(cyc + 3);
    endtask

    task automatic async_reset();
        rstn = 1'b0;
        #1;
        chk("async_ch_rstn", ch_rstn, 0);
        chk("async_ch_tick", ch_tick, 0);
        chk("async_ch_phase", ch_phase, 0);
        chk("async_busy", busy, 0);
        chk("async_seq_done", seq_done, 0);
        evq.delete();
        for (int i = 0; i < N; i++) begin
            rel[i] = INF;
            prev_exp[i] = 0;
        end
        busy_from = INF;
        busy_to   = -1;
        done_from = INF;
    endtask

    task automatic sw_reset(input bit with_load);
        int e;
        step();
        e = cyc + 1;
        sw_rst_req = 1'b1;
        cfg_load   = with_load;
        if (with_load) begin
            for (int i = 0; i < N; i++) begin
                m_dly[i] = p_dly[i];
                m_div[i] = p_div[i];
            end
            load_from = e;
        end
        for (int i = 0; i < N; i++) rel[i] = INF;
        busy_from = e;
        start_seq(e + HC);
        step();
        sw_rst_req = 1'b0;
        cfg_load   = 1'b0;
    endtask

    task automatic ignored_pulse();
        sw_rst_req = 1'b1;
        cfg_load   = 1'b1;
        cfg_div    = N*DW'($urandom);
        cfg_dly    = N*LW'($urandom);
        step();
        sw_rst_req = 1'b0;
        cfg_load   = 1'b0;
        drive_cfg();
    endtask

    task automatic en_drop(input int ch, input int len);
        ch_en[ch] = 1'b0;
        m_en[ch]  = 0;
        repeat (len) step();
        ch_en[ch]   = 1'b1;
        m_en[ch]    = 1;
        en_from[ch] = cyc;
    endtask

    task automatic load_in_done();
        drive_cfg();
        step();
        cfg_load = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_dly[i] = p_dly[i];
            m_div[i] = p_div[i];
        end
        load_from = cyc + 1;
        step();
        cfg_load = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        cfg_load = 1'b0;
        sw_rst_req = 1'b0;
        ch_en = '1;
        p_dly = '{0, 3, 1, 5};
        p_div = '{0, 1, 2, 5};
        for (int i = 0; i < N; i++) begin
            m_dly[i] = p_dly[i];
            m_div[i] = p_div[i];
            rel[i] = INF;
            last_rel[i] = 0;
            en_from[i] = 0;
            m_en[i] = 1;
            prev_exp[i] = 0;
            prev_dut[i] = 0;
        end
        load_from = 0;
        busy_from = INF;
        busy_to   = -1;
        done_from = INF;
        drive_cfg();
        repeat (3) step();

        // power-up with the reference delays, junk pulses during REL, divider rates
        power_up();
        wait_until(rel[1]);
        ignored_pulse();
        wait_until(done_from + 40);

        // software reset, then asynchronous reset between ch1 and ch2 of the resequence
        sw_reset(1'b0);
        wait_until(rel[1]);
        async_reset();
        repeat (3) step();
        power_up();
        wait_until(done_from + 12);

        // enable drop on ch3 then reconfigure its divisor
        en_drop(3, 7);
        repeat (9) step();
        p_div[3] = 3;
        load_in_done();
        repeat (20) step();

        // randomized rounds: new config loaded together with a software reset
        repeat (6) begin
            for (int i = 0; i < N; i++) begin
                p_dly[i] = $urandom_range(0, 6);
                p_div[i] = $urandom_range(0, 6);
            end
            drive_cfg();
            sw_reset(1'b1);
            wait_until(done_from + $urandom_range(5, 20));
            en_drop($urandom_range(0, N - 1), $urandom_range(1, 9));
            repeat ($urandom_range(5, 25)) step();
        end

        chk("release_queue_empty", evq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
